sys_array_feeder: RTL

Input-side driver for the systolic array. It accepts a weight matrix and then a stream of input vectors over a valid/ready handshake. It loads the weights into the array with a one-cycle `weights_load` pulse, then drives `input_data` diagonally skewed: lane k is delayed k extra cycles. It also produces a result-valid strobe aligned to the array's `output_data`, plus a done pulse after the stream drains.

---
 rtl/sys_array_feeder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sys_array_feeder.sv
// Input-side feeder for the systolic array: latches and strobes weights, skews input
// lanes diagonally, tracks which array output cycles carry results, and signals job end.
module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 10,
  parameter int ARRAY_L    = 10,
  parameter int OUT_LAT    = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         reload,
  input  logic signed [DATA_WIDTH-1:0] weight_in [0:ARRAY_W-1][0:ARRAY_L-1],
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] in_data [0:ARRAY_L-1],
  output logic                         weights_load,
  output logic signed [DATA_WIDTH-1:0] weight_data [0:ARRAY_W-1][0:ARRAY_L-1],
  output logic signed [DATA_WIDTH-1:0] input_data [0:ARRAY_L-1],
  output logic                         res_valid,
  output logic [15:0]                  res_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int FLUSH_CYC = (ARRAY_L - 1 > OUT_LAT) ? (ARRAY_L - 1) : OUT_LAT;
  localparam int FC_W      = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {IDLE, WLOAD, STREAM, FLUSH} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          w_done_next;
  logic                          w_latch_w;
  logic                          w_accept;
  logic                          w_flush_end;

  logic                          r_in_ready;
  logic                          r_weights_load;
  logic                          r_busy;
  logic                          r_done;
  logic [15:0]                   r_beat;
  logic [FC_W-1:0]               r_flush_cnt;
  logic signed [DATA_WIDTH-1:0]  r_weight [0:ARRAY_W-1][0:ARRAY_L-1];
  logic                          r_vp_valid [0:OUT_LAT-1];
  logic [15:0]                   r_vp_idx [0:OUT_LAT-1];

  assign w_accept    = in_valid & r_in_ready;
  assign w_flush_end = (r_flush_cnt == FC_W'(FLUSH_CYC - 1));

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_latch_w    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (reload) begin
            w_state_next = WLOAD;
            w_latch_w    = 1'b1;
          end else begin
            w_state_next = STREAM;
          end
        end
      end
      WLOAD:  w_state_next = STREAM;
      STREAM: begin
        if (w_accept && in_last) w_state_next = FLUSH;
      end
      FLUSH: begin
        if (w_flush_end) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b0;
      r_weights_load <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_beat         <= '0;
      r_flush_cnt    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_in_ready     <= (w_state_next == STREAM);
      r_weights_load <= (w_state_next == WLOAD);
      r_busy         <= (w_state_next != IDLE);
      r_done         <= w_done_next;
      if (w_state_next == STREAM && r_state != STREAM) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + 16'd1;
      end
      if (r_state != FLUSH) begin
        r_flush_cnt <= '0;
      end else if (!w_flush_end) begin
        r_flush_cnt <= r_flush_cnt + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ARRAY_W; r++) begin
        for (int c = 0; c < ARRAY_L; c++) begin
          r_weight[r][c] <= '0;
        end
      end
    end else if (w_latch_w) begin
      for (int r = 0; r < ARRAY_W; r++) begin
        for (int c = 0; c < ARRAY_L; c++) begin
          r_weight[r][c] <= weight_in[r][c];
        end
      end
    end
  end

  // Result tracker: bubbles shift through too, so gaps in the input stream survive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < OUT_LAT; s++) begin
        r_vp_valid[s] <= 1'b0;
        r_vp_idx[s]   <= '0;
      end
    end else begin
      r_vp_valid[0] <= w_accept;
      r_vp_idx[0]   <= w_accept ? r_beat : 16'd0;
      for (int s = 1; s < OUT_LAT; s++) begin
        r_vp_valid[s] <= r_vp_valid[s-1];
        r_vp_idx[s]   <= r_vp_idx[s-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_L; gi++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] r_chain [0:gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s <= gi; s++) begin
            r_chain[s] <= '0;
          end
        end else begin
          r_chain[0] <= w_accept ? in_data[gi] : '0;
          for (int s = 1; s <= gi; s++) begin
            r_chain[s] <= r_chain[s-1];
          end
        end
      end

      assign input_data[gi] = r_chain[gi];
    end

    for (gi = 0; gi < ARRAY_W; gi++) begin : g_wrow
      assign weight_data[gi] = r_weight[gi];
    end
  endgenerate

  assign in_ready     = r_in_ready;
  assign weights_load = r_weights_load;
  assign busy         = r_busy;
  assign done         = r_done;
  assign res_valid    = r_vp_valid[OUT_LAT-1];
  assign res_idx      = r_vp_idx[OUT_LAT-1];

endmodule
